// File: rtl/alu.sv
// Registered integer ALU: ADD/SUB/AND/OR/PASSB with zero, negative, carry and
// overflow flags. One-cycle latency, one operation per cycle.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ctrl,
  input  logic             in_valid,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_PASSB = 3'b100;

  localparam int MSB = WIDTH - 1;

  logic             is_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] c_d, c_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  // ADD and SUB share one adder; SUB feeds ~B with a carry-in of 1.
  assign is_sub  = (ctrl == OP_SUB);
  assign b_opnd  = is_sub ? ~B : B;
  assign sum_ext = {1'b0, A} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
  assign sum     = sum_ext[WIDTH-1:0];

  always_comb begin
    c_d     = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (ctrl)
      OP_ADD: begin
        c_d     = sum;
        carry_d = sum_ext[WIDTH];
        ovf_d   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        c_d     = sum;
        carry_d = sum_ext[WIDTH];
        ovf_d   = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_AND:   c_d = A & B;
      OP_OR:    c_d = A | B;
      OP_PASSB: c_d = B;
      default:  c_d = '0;
    endcase
    zero_d = (c_d == '0);
    neg_d  = c_d[MSB];
  end

  // Result registers only load on valid input; out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        c_q     <= c_d;
        zero_q  <= zero_d;
        neg_q   <= neg_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign C         = c_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases from the test plan plus
// randomized traffic, all checked against an arithmetic reference model.
module tb_alu;

  localparam int W = 64;
  localparam logic signed [W+1:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [W+1:0] SMIN = -SMAX - 66'sd1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [2:0]   ctrl = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] C;
  logic         zero, negative, carry, overflow, out_valid;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: what the outputs should show right now.
  logic [W-1:0] m_c;
  logic         m_z, m_n, m_cy, m_ov, m_v;

  logic [W-1:0] corners [8];

  alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ctrl(ctrl), .in_valid(in_valid),
    .C(C), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".C"},         C,                 m_c);
    check({tag, ".zero"},      {63'd0, zero},     {63'd0, m_z});
    check({tag, ".negative"},  {63'd0, negative}, {63'd0, m_n});
    check({tag, ".carry"},     {63'd0, carry},    {63'd0, m_cy});
    check({tag, ".overflow"},  {63'd0, overflow}, {63'd0, m_ov});
    check({tag, ".out_valid"}, {63'd0, out_valid},{63'd0, m_v});
  endtask

  task automatic model_reset();
    m_c = '0; m_z = 1'b1; m_n = 1'b0; m_cy = 1'b0; m_ov = 1'b0; m_v = 1'b0;
  endtask

  // Behavioural model: exact unsigned/signed arithmetic, then range tests.
  task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic v);
    logic [W:0] u;
    logic signed [W+1:0] sa, sb, s;
    m_v = v;
    if (!v) return;
    sa = $signed(a);
    sb = $signed(b);
    m_cy = 1'b0;
    m_ov = 1'b0;
    case (op)
      3'd0: begin
        u = {1'b0, a} + {1'b0, b};
        m_c = a + b;
        m_cy = u[W];
        s = sa + sb;
        m_ov = (s > SMAX) || (s < SMIN);
      end
      3'd1: begin
        m_c = a - b;
        m_cy = (a >= b);
        s = sa - sb;
        m_ov = (s > SMAX) || (s < SMIN);
      end
      3'd2: m_c = a & b;
      3'd3: m_c = a | b;
      3'd4: m_c = b;
      default: m_c = '0;
    endcase
    m_z = (m_c == '0);
    m_n = m_c[W-1];
  endtask

  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic v);
    @(negedge clk);
    A = a; B = b; ctrl = op; in_valid = v;
    @(posedge clk);
    model_op(a, b, op, v);
    #1;
    check_all(tag);
  endtask

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 7)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    corners[0] = '0;
    corners[1] = 64'd1;
    corners[2] = '1;
    corners[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    corners[4] = 64'h8000_0000_0000_0000;
    corners[5] = 64'hF0F0_F0F0;
    corners[6] = 64'h0F0F_0F0F;
    corners[7] = 64'h5555_5555;

    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply("add_5_3",       64'd5, 64'd3, 3'b000, 1'b1);
    apply("sub_5_5",       64'd5, 64'd5, 3'b001, 1'b1);
    apply("sub_0_1",       64'd0, 64'd1, 3'b001, 1'b1);
    apply("and_f0_0f",     64'hF0F0_F0F0, 64'h0F0F_0F0F, 3'b010, 1'b1);
    apply("or_f0_0f",      64'hF0F0_F0F0, 64'h0F0F_0F0F, 3'b011, 1'b1);
    apply("passb",         64'hAAAA_AAAA, 64'h5555_5555, 3'b100, 1'b1);
    apply("undef_111",     64'hAAAA_AAAA, 64'h5555_5555, 3'b111, 1'b1);
    apply("add_ovf",       64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 1'b1);
    apply("add_wrap",      '1, 64'd1, 3'b000, 1'b1);
    apply("sub_minneg_1",  64'h8000_0000_0000_0000, 64'd1, 3'b001, 1'b1);
    apply("hold",          64'd9, 64'd9, 3'b000, 1'b0);
    apply("hold2",         64'd1, 64'd2, 3'b011, 1'b0);

    // Reset pulsed between edges must clear outputs without a clock.
    apply("pre_rst",       64'h1234, '1, 3'b000, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst_idle");

    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      logic [2:0] op;
      logic v;
      a = pick();
      b = pick();
      op = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 4) != 0);
      apply($sformatf("rnd%0d", i), a, b, op, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
